// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, even parity bit, stop bit; each bit lasts CLKS_PER_BIT cycles.
// First bit is driven the cycle after accept; in_ready is low for the whole frame and words offered meanwhile are ignored.
module parity_frame_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              parity_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic              tx_nxt, busy_nxt, done_nxt, parity_nxt;
  logic              bit_end;

  assign bit_end  = (clk_cnt == CLK_LAST);
  assign in_ready = (state == IDLE);

  // tx is only ever reloaded at a bit boundary, so the line never glitches mid-bit.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    tx_nxt      = tx;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    parity_nxt  = parity_out;

    if (state != IDLE) begin
      clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt   = START;
          shift_nxt   = in_data;
          parity_nxt  = ^in_data;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          clk_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = PARITY;
            tx_nxt    = parity_out;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_nxt      = shift_nxt[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      parity_out <= parity_nxt;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three instances (CLKS_PER_BIT 4, 1, 2), scoreboard of accepted words
// checked against the serial line history whenever a done pulse appears.
module tb_parity_frame_tx;

  localparam int W  = 4;
  localparam int HN = 20000;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame bit k of the serial sequence for word d.
  function automatic logic frame_bit(input logic [W-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
    if (k == W + 1) return ($countones(d) % 2) == 1;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int CPB = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    localparam int F   = (W + 3) * CPB;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, tx, busy, done, parity_out;
    logic         fin = 1'b0;
    logic [W-1:0] q_d[$];
    int           q_t[$];
    logic         hist [HN];
    logic [W-1:0] md;
    int           mt, bad;

    parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .tx(tx), .busy(busy), .done(done), .parity_out(parity_out)
    );

    // Monitor: log the line every cycle, and on each done pulse compare the finished frame.
    always @(negedge clk) begin
      if (cyc < HN) hist[cyc] = tx;
      if (done === 1'b1) begin
        if (q_d.size() == 0) begin
          chk($sformatf("u%0d_spurious_done", g), 1, 0);
        end else begin
          md = q_d.pop_front();
          mt = q_t.pop_front();
          chk($sformatf("u%0d_done_time", g), cyc - mt, F);
          bad = 0;
          for (int j = 0; j < F; j++)
            if (mt + j >= HN || hist[mt + j] !== frame_bit(md, j / CPB)) bad++;
          chk($sformatf("u%0d_tx_bits_word%0h", g, md), bad, 0);
          chk($sformatf("u%0d_parity_word%0h", g, md), int'(parity_out), $countones(md) % 2);
          chk($sformatf("u%0d_gap_tx", g), int'(tx), 1);
          chk($sformatf("u%0d_end_busy", g), int'(busy), 0);
          chk($sformatf("u%0d_end_ready", g), int'(in_ready), 1);
        end
      end
    end

    task automatic send(input logic [W-1:0] d, input bit hold, output int t);
      t = -1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < F + 8 && in_ready !== 1'b1; i++) @(negedge clk);
      if (in_ready !== 1'b1) begin
        chk($sformatf("u%0d_accept_timeout", g), 0, 1);
        in_valid = 1'b0;
        return;
      end
      t = cyc + 1;
      q_d.push_back(d);
      q_t.push_back(t);
      @(posedge clk);
      #1;
      in_valid = hold;
      if (!hold) in_data = W'($urandom);
    endtask

    task automatic wait_idle();
      for (int i = 0; i < 2 * F + 10 && q_d.size() != 0; i++) @(negedge clk);
      chk($sformatf("u%0d_queue_drain", g), q_d.size(), 0);
    endtask

    task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk({tag, "_tx"}, int'(tx), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_parity"}, int'(parity_out), 0);
      chk({tag, "_ready"}, int'(in_ready), 1);
    endtask

    if (g == 0) begin : s0
      initial begin
        int t;
        do_reset("u0_por");
        // Reset and valid on the same edge: nothing may be accepted.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 4'h5;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("u0_rstprio_ready", int'(in_ready), 1);
        chk("u0_rstprio_busy", int'(busy), 0);
        @(negedge clk);
        chk("u0_rstprio_idle_busy", int'(busy), 0);
        chk("u0_rstprio_idle_tx", int'(tx), 1);

        send(4'b1011, 1'b0, t);
        wait_idle();
        chk("u0_parity_1011", int'(parity_out), 1);

        // A word offered mid-frame must be dropped.
        send(4'h1, 1'b0, t);
        repeat (6) @(negedge clk);
        in_valid = 1'b1; in_data = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("u0_ignore_parity", int'(parity_out), 1);
        chk("u0_ignore_busy", int'(busy), 0);

        // Reset during data bit 2 abandons the frame.
        send(4'h6, 1'b0, t);
        while (cyc < t + 3 * CPB) @(negedge clk);
        void'(q_d.pop_back());
        void'(q_t.pop_back());
        do_reset("u0_midframe");
        send(4'h3, 1'b0, t);
        wait_idle();

        repeat (40) begin
          send(W'($urandom), 1'b0, t);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        fin = 1'b1;
      end
    end else if (g == 1) begin : s1
      initial begin
        int t, p;
        p = 0;
        do_reset("u1_por");
        for (int d = 0; d < 16; d++) begin
          send(W'(d), d < 15, t);
          if (d > 0) chk($sformatf("u1_spacing_%0d", d), t - p, F + 1);
          p = t;
        end
        wait_idle();
        fin = 1'b1;
      end
    end else begin : s2
      initial begin
        int t1, t2;
        do_reset("u2_por");
        send(4'h5, 1'b1, t1);
        send(4'hA, 1'b0, t2);
        chk("u2_b2b_spacing", t2 - t1, 15);
        wait_idle();
        fin = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(u[0].fin && u[1].fin && u[2].fin); i++) @(negedge clk);
    chk("all_finished", int'(u[0].fin & u[1].fin & u[2].fin), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial frame transmitter built around the team's 4-input even parity bit generator function.
- Accepts a DATA_W-bit word over a valid/ready handshake and computes its even parity bit.
- Shifts out a fixed frame: start bit, data LSB-first, parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a word producer and a single-wire serial link; it is the sequencer that drives the parity datapath.

Parameters:
- DATA_W, 4, data word width in bits; legal range 1..16. Default matches the 4-bit parity generator.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..65535.

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  word to transmit
- tx  output  1  serial line; idles high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse when a frame completes
- parity_out  output  1  even parity bit of the last accepted word

Behaviour:
- **Reset:** when rst=1 at a clk edge, the block enters IDLE. All outputs take these values the following cycle: tx=1, busy=0, done=0, parity_out=0, in_ready=1. Internal counters clear to 0.
- **Reset priority:** rst overrides all other inputs. Reset mid-frame abandons the frame: tx returns to 1, no done pulse is issued.
- **States:** IDLE, START, DATA, PARITY, STOP. All outputs are registered except in_ready, which equals (state==IDLE).
- **Accept:** a word is accepted at an edge where in_valid=1 and in_ready=1.
  - At that edge, in_data is captured into a shift register.
  - parity_out <= XOR of all in_data bits, so data ones plus parity bit is even.
  - FSM goes to START and busy goes to 1.
  - in_data changes after the accept edge have no effect.
- **START:** tx=0 for CLKS_PER_BIT cycles, then DATA.
- **DATA:** tx = shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right. DATA_W bits are sent LSB first, then PARITY.
- **PARITY:** tx = parity_out for CLKS_PER_BIT cycles, then STOP.
- **STOP:** tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - On the transition edge: busy<=0, done<=1 for exactly one cycle.
  - done is high in the first IDLE cycle, concurrent with in_ready=1.
- **Frame timing:** accept at edge T. tx=0 from cycle T+1. Frame occupies (DATA_W+3)*CLKS_PER_BIT cycles. First possible next accept is at edge T+(DATA_W+3)*CLKS_PER_BIT+1.
- **Inter-frame gap:** back-to-back frames have a 1-cycle minimum idle gap with tx=1. This is the IDLE cycle in which done=1.
- **Busy handshake:** in_valid while busy is ignored; no queueing. The producer must hold in_valid until it sees in_ready.
- **Clock divider:** counter of width max(1,$clog2(CLKS_PER_BIT)). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- **CLKS_PER_BIT=1:** every bit lasts one cycle. No divider-dependent special cases are permitted.
- **Bit counter:** width $clog2(DATA_W+1). Cleared on entry to DATA.
- **Glitch-free tx:** tx changes only on bit boundaries.

Test Plan:
1. DATA_W=4, CLKS_PER_BIT=4, send in_data=4'b1011 -> parity_out=1. tx over 28 cycles is 0,1,1,0,1,1,1, each bit held 4 cycles. done pulses once, at cycle 29 after accept.
2. Exhaustive: send all 16 nibbles with CLKS_PER_BIT=1. Each frame is exactly 7 cycles. parity_out must equal a^b^c^d each time, and the total ones in the data+parity bits must be even. Example: 4'b0000 gives tx 0,0,0,0,0,0,1 with parity 0.
3. Back-to-back: hold in_valid=1 with 4'h5 then 4'hA, CLKS_PER_BIT=2.
   - Second accept occurs exactly 15 cycles after the first.
   - One tx=1 gap cycle separates the frames.
   - Parity bits are 0 and 0.
4. Busy ignore: pulse in_valid with 4'hF mid-frame while sending 4'h1. The 4'hF word is not transmitted, parity_out stays 1, and no extra done pulse occurs.
5. Reset mid-frame: assert rst for 1 cycle during the DATA bit 2 of 4'h6.
   - Next cycle: tx=1, busy=0, parity_out=0, in_ready=1, no done.
   - A subsequent 4'h3 frame transmits correctly with parity 0.
6. Reset priority: assert rst and in_valid on the same edge -> no word is accepted and the block stays in IDLE.
